// File: rtl/video_mode_ctrl.sv
// Background mode selector: button presses (or optional auto-advance, enabled by the
// VIDEO_MODE_AUTOCYCLE_EN macro) step mode_out 00 -> 10 -> 11 -> 00 at frame boundaries.
module video_mode_ctrl #(
  parameter int unsigned HOLDOFF_FRAMES     = 4,
  parameter int unsigned AUTO_PERIOD_FRAMES = 120
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       btn_in,
  input  logic       new_frame_in,
  input  logic       auto_en_in,
  output logic [1:0] mode_out,
  output logic       mode_changed_out,
  output logic       pending_out
);

  typedef enum logic [1:0] {StIdle, StPending, StHold} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLDOFF_FRAMES - 1);

  state_e     r_state, w_state_d;
  logic [1:0] r_mode, w_mode_d;
  logic       r_mode_changed, w_mode_changed_d;
  logic [7:0] r_hold_cnt, w_hold_cnt_d;
  logic       r_btn_prev;
  logic       w_press;
  logic       w_auto_fire;
  logic       w_start;

  assign w_press = btn_in & ~r_btn_prev;

`ifdef VIDEO_MODE_AUTOCYCLE_EN
  localparam logic [11:0] AutoLast = 12'(AUTO_PERIOD_FRAMES - 1);

  logic [11:0] r_auto_cnt, w_auto_cnt_d;

  // Counter only runs while idle and enabled; a manual press wins the same cycle.
  always_comb begin
    w_auto_cnt_d = '0;
    w_auto_fire  = 1'b0;
    if (r_state == StIdle && auto_en_in) begin
      w_auto_cnt_d = r_auto_cnt;
      if (new_frame_in && !w_press) begin
        if (r_auto_cnt == AutoLast) begin
          w_auto_fire  = 1'b1;
          w_auto_cnt_d = '0;
        end else begin
          w_auto_cnt_d = r_auto_cnt + 12'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= w_auto_cnt_d;
    end
  end
`else
  logic w_unused_auto_en;
  assign w_unused_auto_en = auto_en_in;
  assign w_auto_fire      = 1'b0;
`endif

  assign w_start = w_press | w_auto_fire;

  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    case (mode)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    w_state_d        = r_state;
    w_mode_d         = r_mode;
    w_mode_changed_d = 1'b0;
    w_hold_cnt_d     = r_hold_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_start) w_state_d = StPending;
      end
      StPending: begin
        if (new_frame_in) begin
          w_state_d        = StHold;
          w_mode_d         = next_mode(r_mode);
          w_mode_changed_d = 1'b1;
          w_hold_cnt_d     = '0;
        end
      end
      StHold: begin
        // The entry frame pulse is not counted; presses are dropped throughout.
        if (HOLDOFF_FRAMES == 0) begin
          w_state_d = StIdle;
        end else if (new_frame_in) begin
          if (r_hold_cnt == HoldLast) begin
            w_state_d    = StIdle;
            w_hold_cnt_d = '0;
          end else begin
            w_hold_cnt_d = r_hold_cnt + 8'd1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= StIdle;
      r_mode         <= 2'b00;
      r_mode_changed <= 1'b0;
      r_hold_cnt     <= '0;
      r_btn_prev     <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_mode         <= w_mode_d;
      r_mode_changed <= w_mode_changed_d;
      r_hold_cnt     <= w_hold_cnt_d;
      r_btn_prev     <= btn_in;
    end
  end

  assign mode_out         = r_mode;
  assign mode_changed_out = r_mode_changed;
  assign pending_out      = (r_state == StPending);

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl: scoreboard of expected mode updates plus
// point checks; a second instance exercises auto-advance (VIDEO_MODE_AUTOCYCLE_EN).
module tb_video_mode_ctrl;

`ifdef VIDEO_MODE_AUTOCYCLE_EN
  localparam bit AutoOn = 1'b1;
`else
  localparam bit AutoOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       new_frame = 1'b0;
  logic       auto_en1 = 1'b0;
  logic       auto_en2 = 1'b0;
  logic [1:0] mode1, mode2;
  logic       changed1, changed2;
  logic       pending1, pending2;

  int         n_pass = 0;
  int         n_total = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  video_mode_ctrl #(
    .HOLDOFF_FRAMES    (4),
    .AUTO_PERIOD_FRAMES(120)
  ) dut1 (
    .clk_in          (clk),
    .rst_in          (rst),
    .btn_in          (btn),
    .new_frame_in    (new_frame),
    .auto_en_in      (auto_en1),
    .mode_out        (mode1),
    .mode_changed_out(changed1),
    .pending_out     (pending1)
  );

  video_mode_ctrl #(
    .HOLDOFF_FRAMES    (0),
    .AUTO_PERIOD_FRAMES(3)
  ) dut2 (
    .clk_in          (clk),
    .rst_in          (rst),
    .btn_in          (btn),
    .new_frame_in    (new_frame),
    .auto_en_in      (auto_en2),
    .mode_out        (mode2),
    .mode_changed_out(changed2),
    .pending_out     (pending2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    new_frame = 1'b1;
    cyc(1);
    new_frame = 1'b0;
  endtask

  task automatic press();
    btn = 1'b1;
    cyc(1);
    btn = 1'b0;
  endtask

  task automatic hold_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame();
      cyc(3);
    end
  endtask

  // Each mode update pulse pops the next expected mode; 01 stands in for "nothing expected".
  always @(negedge clk) begin
    logic [1:0] exp_mode;
    if (!rst && changed1) begin
      exp_mode = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b01;
      check("sb_mode_update", 32'(mode1), 32'(exp_mode));
    end
  end

  initial begin
    // Reset state
    cyc(3);
    check("rst_mode", 32'(mode1), 32'd0);
    check("rst_pending", 32'(pending1), 32'd0);
    check("rst_changed", 32'(changed1), 32'd0);
    rst = 1'b0;
    cyc(2);

    // Press, then frame 10 cycles later -> 00 -> 10
    press();
    check("pend_c1", 32'(pending1), 32'd1);
    for (int i = 2; i <= 10; i++) begin
      cyc(1);
      check("pend_hold", 32'(pending1), 32'd1);
    end
    check("pend_mode_unchanged", 32'(mode1), 32'd0);
    exp_q.push_back(2'b10);
    frame();
    check("adv1_mode", 32'(mode1), 32'd2);
    check("adv1_changed", 32'(changed1), 32'd1);
    check("adv1_pending", 32'(pending1), 32'd0);
    cyc(1);
    check("adv1_pulse_end", 32'(changed1), 32'd0);
    cyc(2);

    // Holdoff: press during frame 2 ignored, accepted after the 4th frame
    hold_frames(2);
    press();
    check("hold_press_ignored", 32'(pending1), 32'd0);
    hold_frames(2);
    check("hold_mode_kept", 32'(mode1), 32'd2);
    press();
    check("post_hold_press", 32'(pending1), 32'd1);
    exp_q.push_back(2'b11);
    frame();
    check("adv2_mode", 32'(mode1), 32'd3);
    cyc(3);
    hold_frames(4);

    // Press coincident with frame: pending only, switch on next frame
    btn = 1'b1;
    new_frame = 1'b1;
    cyc(1);
    btn = 1'b0;
    new_frame = 1'b0;
    check("coinc_pending", 32'(pending1), 32'd1);
    check("coinc_no_change", 32'(mode1), 32'd3);
    cyc(2);
    press();
    exp_q.push_back(2'b00);
    frame();
    check("adv3_mode", 32'(mode1), 32'd0);
    cyc(3);
    hold_frames(4);
    check("no_queued_press", 32'(pending1), 32'd0);

    // Reset while pending discards the request
    exp_q.push_back(2'b10);
    press();
    frame();
    cyc(3);
    hold_frames(4);
    press();
    check("pre_rst_pending", 32'(pending1), 32'd1);
    rst = 1'b1;
    cyc(1);
    check("rst_pend_mode", 32'(mode1), 32'd0);
    check("rst_pend_pending", 32'(pending1), 32'd0);
    rst = 1'b0;
    cyc(2);
    frame();
    check("rst_pend_no_change", 32'(mode1), 32'd0);
    check("rst_pend_still_idle", 32'(pending1), 32'd0);
    cyc(2);

    // Button held through reset release counts as a press
    rst = 1'b1;
    btn = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check("btn_through_rst", 32'(pending1), 32'd1);
    btn = 1'b0;
    rst = 1'b1;
    auto_en2 = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Auto-advance on dut2: period 3, no holdoff
    for (int k = 1; k <= 8; k++) begin
      frame();
      if (k == 2) check("auto_f2_idle", 32'(pending2), 32'd0);
      if (k == 3) check("auto_f3_pending", 32'(pending2), 32'(AutoOn));
      if (k == 4) begin
        check("auto_f4_mode", 32'(mode2), AutoOn ? 32'd2 : 32'd0);
        check("auto_f4_changed", 32'(changed2), 32'(AutoOn));
      end
      if (k == 7) check("auto_f7_pending", 32'(pending2), 32'(AutoOn));
      if (k == 8) check("auto_f8_mode", 32'(mode2), AutoOn ? 32'd3 : 32'd0);
      cyc(3);
    end
    check("auto_dut1_unaffected", 32'(mode1), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
